// File: rtl/tail_light_seq_pkg.sv
// Shared types and lamp constants for the tail-light sequencer.
// Lamp order, MSB to LSB: LC LB LA RA RB RC, with LA/RA innermost.
package tail_light_seq_pkg;

  localparam int unsigned NUM_LAMPS = 6;

  localparam int unsigned LAMP_RC = 0;
  localparam int unsigned LAMP_RB = 1;
  localparam int unsigned LAMP_RA = 2;
  localparam int unsigned LAMP_LA = 3;
  localparam int unsigned LAMP_LB = 4;
  localparam int unsigned LAMP_LC = 5;

  typedef logic [NUM_LAMPS-1:0] lamps_t;

  localparam lamps_t PAT_OFF = 6'b000000;
  localparam lamps_t PAT_ALL = 6'b111111;
  localparam lamps_t PAT_L1  = 6'b001000;
  localparam lamps_t PAT_L2  = 6'b011000;
  localparam lamps_t PAT_L3  = 6'b111000;
  localparam lamps_t PAT_R1  = 6'b000100;
  localparam lamps_t PAT_R2  = 6'b000110;
  localparam lamps_t PAT_R3  = 6'b000111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_L1,
    ST_L2,
    ST_L3,
    ST_R1,
    ST_R2,
    ST_R3,
    ST_HAZ_ON,
    ST_HAZ_OFF
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_LEFT,
    REQ_RIGHT,
    REQ_HAZ
  } req_e;

  // Un-overlaid lamp pattern shown while sitting in a state.
  function automatic lamps_t base_pattern(input state_e st);
    lamps_t pat;
    pat = PAT_OFF;
    case (st)
      ST_L1:     pat = PAT_L1;
      ST_L2:     pat = PAT_L2;
      ST_L3:     pat = PAT_L3;
      ST_R1:     pat = PAT_R1;
      ST_R2:     pat = PAT_R2;
      ST_R3:     pat = PAT_R3;
      ST_HAZ_ON: pat = PAT_ALL;
      default:   pat = PAT_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/tail_light_seq_if.sv
// Request inputs and lamp/dimmer outputs of the tail-light sequencer.
interface tail_light_seq_if
  import tail_light_seq_pkg::*;
();

  logic   left;
  logic   right;
  logic   hazard;
  logic   brake;
  logic   headlights;
  lamps_t lamps;
  logic   dim_clk;
  logic   dim_en;

  modport master (
    output left, right, hazard, brake, headlights,
    input  lamps, dim_clk, dim_en
  );

  modport slave (
    input  left, right, hazard, brake, headlights,
    output lamps, dim_clk, dim_en
  );

endinterface

// File: rtl/pwm_strobe.sv
// Free-running PWM strobe: high for the first DUTY counts of every PERIOD.
// Output is registered, so the first high cycle directly follows reset release.
module pwm_strobe #(
  parameter int unsigned PERIOD = 8,
  parameter int unsigned DUTY   = 2
) (
  input  logic clock,
  input  logic resetn,
  output logic strobe
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q, strobe_d;

  always_comb begin
    cnt_d = (cnt_q == CW'(PERIOD - 1)) ? '0 : cnt_q + CW'(1);
  end

  // Degenerate duties resolved at elaboration so no constant compare remains.
  if (DUTY == 0) begin : g_off
    always_comb strobe_d = 1'b0;
  end else if (DUTY >= PERIOD) begin : g_on
    always_comb strobe_d = 1'b1;
  end else begin : g_cmp
    always_comb strobe_d = (cnt_q < CW'(DUTY));
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/tail_light_seq.sv
// Turn/hazard/brake tail-light sequencer: step prescaler, sequencing FSM,
// brake overlay on the registered lamp pattern, and the PWM dimming strobe.
module tail_light_seq
  import tail_light_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned PWM_PERIOD = 8,
  parameter int unsigned PWM_DUTY   = 2
) (
  input  logic             clock,
  input  logic             resetn,
  tail_light_seq_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  lamps_t        lamps_q, lamps_d;
  logic          dim_en_q, dim_en_d;
  logic          dim_clk;
  logic          tick;
  req_e          req;

  // Request priority: hazard (or both turns), left, right.
  always_comb begin
    req = REQ_NONE;
    if (bus.hazard || (bus.left && bus.right)) req = REQ_HAZ;
    else if (bus.left)                         req = REQ_LEFT;
    else if (bus.right)                        req = REQ_RIGHT;
  end

  always_comb begin
    tick = (presc_q == PW'(TICK_DIV - 1));
  end

  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        case (req)
          REQ_HAZ:   state_d = ST_HAZ_ON;
          REQ_LEFT:  state_d = ST_L1;
          REQ_RIGHT: state_d = ST_R1;
          default:   state_d = ST_IDLE;
        endcase
      end
      ST_L1, ST_L2, ST_L3: begin
        if (tick) begin
          if (req == REQ_HAZ)       state_d = ST_HAZ_ON;
          else if (req != REQ_LEFT) state_d = ST_IDLE;
          else if (state_q == ST_L1) state_d = ST_L2;
          else if (state_q == ST_L2) state_d = ST_L3;
          else                      state_d = ST_IDLE;
        end
      end
      ST_R1, ST_R2, ST_R3: begin
        if (tick) begin
          if (req == REQ_HAZ)        state_d = ST_HAZ_ON;
          else if (req != REQ_RIGHT) state_d = ST_IDLE;
          else if (state_q == ST_R1) state_d = ST_R2;
          else if (state_q == ST_R2) state_d = ST_R3;
          else                       state_d = ST_IDLE;
        end
      end
      ST_HAZ_ON, ST_HAZ_OFF: begin
        if (tick) begin
          if (req != REQ_HAZ)            state_d = ST_IDLE;
          else if (state_q == ST_HAZ_ON) state_d = ST_HAZ_OFF;
          else                           state_d = ST_HAZ_ON;
        end
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
      end
    endcase
  end

  // Brake lights the half not used by the turn sequence; hazard ignores it.
  always_comb begin
    lamps_d  = base_pattern(state_d);
    dim_en_d = bus.headlights;
    if (bus.brake) begin
      case (state_d)
        ST_IDLE:             lamps_d = PAT_ALL;
        ST_L1, ST_L2, ST_L3: lamps_d[LAMP_RA:LAMP_RC] = '1;
        ST_R1, ST_R2, ST_R3: lamps_d[LAMP_LC:LAMP_LA] = '1;
        default:             lamps_d = base_pattern(state_d);
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      lamps_q  <= PAT_OFF;
      dim_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      lamps_q  <= lamps_d;
      dim_en_q <= dim_en_d;
    end
  end

  pwm_strobe #(
    .PERIOD (PWM_PERIOD),
    .DUTY   (PWM_DUTY)
  ) u_pwm (
    .clock  (clock),
    .resetn (resetn),
    .strobe (dim_clk)
  );

  assign bus.lamps   = lamps_q;
  assign bus.dim_clk = dim_clk;
  assign bus.dim_en  = dim_en_q;

endmodule

// File: tb/tb_tail_light_seq.sv
// Directed bench for tail_light_seq: lamp sequences, brake overlay,
// hazard takeover, reset behaviour and PWM strobe at three duty settings.
module tb_tail_light_seq;

  logic clk;
  logic resetn;
  logic left, right, hazard, brake, headlights;

  int n_chk;
  int n_pass;

  tail_light_seq_if bus_m ();
  tail_light_seq_if bus_z ();
  tail_light_seq_if bus_f ();

  assign bus_m.left = left;  assign bus_m.right = right;  assign bus_m.hazard = hazard;
  assign bus_m.brake = brake; assign bus_m.headlights = headlights;
  assign bus_z.left = left;  assign bus_z.right = right;  assign bus_z.hazard = hazard;
  assign bus_z.brake = brake; assign bus_z.headlights = headlights;
  assign bus_f.left = left;  assign bus_f.right = right;  assign bus_f.hazard = hazard;
  assign bus_f.brake = brake; assign bus_f.headlights = headlights;

  tail_light_seq #(.TICK_DIV(4), .PWM_PERIOD(8), .PWM_DUTY(2)) dut (
    .clock (clk), .resetn (resetn), .bus (bus_m)
  );
  tail_light_seq #(.TICK_DIV(4), .PWM_PERIOD(8), .PWM_DUTY(0)) dut_d0 (
    .clock (clk), .resetn (resetn), .bus (bus_z)
  );
  tail_light_seq #(.TICK_DIV(4), .PWM_PERIOD(8), .PWM_DUTY(8)) dut_d8 (
    .clock (clk), .resetn (resetn), .bus (bus_f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] act, input logic [5:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_n(input string tag, input int n, input logic [5:0] pat);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, bus_m.lamps, pat);
    end
  endtask

  initial begin
    clk = 1'b0;
    n_chk = 0;
    n_pass = 0;
    resetn = 1'b0;
    left = 1'b1; right = 1'b1; hazard = 1'b1; brake = 1'b1; headlights = 1'b1;

    step();
    chk("rst_lamps", bus_m.lamps, 6'b000000);
    chk("rst_dimclk", 6'(bus_m.dim_clk), 6'd0);
    chk("rst_dimen", 6'(bus_m.dim_en), 6'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_hold_lamps", bus_m.lamps, 6'b000000);
      chk("rst_hold_dimen", 6'(bus_m.dim_en), 6'd0);
      chk("rst_hold_dimclk", 6'(bus_f.dim_clk), 6'd0);
    end

    resetn = 1'b1;
    left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("pwm_d2", 6'(bus_m.dim_clk), ((i % 8) < 2) ? 6'd1 : 6'd0);
      chk("pwm_d0", 6'(bus_z.dim_clk), 6'd0);
      chk("pwm_d8", 6'(bus_f.dim_clk), 6'd1);
      if (i == 0) begin
        chk("dimen_on", 6'(bus_m.dim_en), 6'd1);
        chk("idle_lamps", bus_m.lamps, 6'b000000);
      end
    end

    left = 1'b1;
    expect_n("left_l1", 4, 6'b001000);
    expect_n("left_l2", 4, 6'b011000);
    expect_n("left_l3", 4, 6'b111000);
    expect_n("left_off", 1, 6'b000000);
    expect_n("left_l1_again", 1, 6'b001000);
    left = 1'b0;
    expect_n("left_drop_hold", 3, 6'b001000);
    expect_n("left_drop_idle", 1, 6'b000000);

    right = 1'b1;
    expect_n("right_r1", 4, 6'b000100);
    expect_n("right_r2", 1, 6'b000110);
    brake = 1'b1;
    expect_n("right_r2_brake", 1, 6'b111110);
    brake = 1'b0;
    expect_n("right_r2_release", 1, 6'b000110);
    right = 1'b0;
    expect_n("right_r2_last", 1, 6'b000110);
    expect_n("right_idle", 1, 6'b000000);

    left = 1'b1;
    expect_n("haz_l1", 4, 6'b001000);
    expect_n("haz_l2", 1, 6'b011000);
    hazard = 1'b1;
    expect_n("haz_l2_wait", 3, 6'b011000);
    expect_n("haz_on", 4, 6'b111111);
    brake = 1'b1;
    expect_n("haz_off_brake", 4, 6'b000000);
    expect_n("haz_on_brake", 4, 6'b111111);
    hazard = 1'b0; left = 1'b0; brake = 1'b0;
    expect_n("haz_end_idle", 1, 6'b000000);

    brake = 1'b1;
    expect_n("brake_idle", 1, 6'b111111);
    brake = 1'b0;
    expect_n("brake_idle_rel", 1, 6'b000000);

    left = 1'b1; right = 1'b1;
    expect_n("lr_haz_on", 4, 6'b111111);
    expect_n("lr_haz_off", 1, 6'b000000);
    left = 1'b0; right = 1'b0;
    expect_n("lr_idle", 4, 6'b000000);

    headlights = 1'b0;
    step();
    chk("dimen_off", 6'(bus_m.dim_en), 6'd0);

    left = 1'b1;
    expect_n("mid_rst_l1", 2, 6'b001000);
    resetn = 1'b0;
    expect_n("mid_rst_abort", 1, 6'b000000);
    resetn = 1'b1;
    left = 1'b0;
    expect_n("mid_rst_idle", 1, 6'b000000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
